// File: rtl/timer_entry_pkg.sv
// timer_entry_pkg: shared constants and key FSM encoding for the timer-entry path
package timer_entry_pkg;
  localparam int BCD_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_DIGIT = 9;
  typedef enum logic [1:0] {IDLE, PRESS, ACCEPT, RELEASE} key_state_t;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes loadn/code and emits one press pulse per clean keypress
module key_debouncer
  import timer_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [BCD_W-1:0] i_code,
  input  logic             i_loadn,
  output logic             o_press_pulse,
  output logic [BCD_W-1:0] o_code
);
  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);
  logic [BCD_W:0] r_sync1, r_sync2;
  key_state_t r_state, w_state_nx;
  logic [DEB_W-1:0] r_cnt, w_cnt_nx;
  logic [BCD_W-1:0] r_code, w_code_nx;
  logic w_loadn;
  logic [BCD_W-1:0] w_code;
  assign w_loadn = r_sync2[BCD_W];
  assign w_code = r_sync2[BCD_W-1:0];
  assign o_press_pulse = (r_state == ACCEPT);
  assign o_code = r_code;
  // two-flop synchronizer, idles high so reset looks like "no key"
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {i_loadn, i_code};
      r_sync2 <= r_sync1;
    end
  end
  // state, stability counter and latched code
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_code <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_code <= w_code_nx;
    end
  end
  // press must stay stable DEB_CYCLES cycles; release must stay high DEB_CYCLES cycles
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_code_nx = r_code;
    case (r_state)
      IDLE: begin
        if (!w_loadn) begin
          w_state_nx = (DEB_CYCLES == 1) ? ACCEPT : PRESS;
          w_code_nx = w_code;
          w_cnt_nx = (DEB_CYCLES == 1) ? '0 : DEB_W'(1);
        end
      end
      PRESS: begin
        if (w_loadn) begin
          w_state_nx = IDLE;
          w_cnt_nx = '0;
        end else if (w_code != r_code) begin
          w_code_nx = w_code;
          w_cnt_nx = DEB_W'(1);
        end else if (r_cnt >= LAST) begin
          w_state_nx = ACCEPT;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + DEB_W'(1);
        end
      end
      ACCEPT: begin
        w_state_nx = RELEASE;
        w_cnt_nx = '0;
      end
      default: begin
        if (!w_loadn) begin
          w_cnt_nx = '0;
        end else if (r_cnt >= LAST) begin
          w_state_nx = IDLE;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + DEB_W'(1);
        end
      end
    endcase
  end
endmodule

// File: rtl/keypad_digit_register.sv
// keypad_digit_register: turns debounced keypresses into a 4-digit BCD MM:SS entry register
module keypad_digit_register
  import timer_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  D,
  input  logic        loadn,
  input  logic        enablen,
  input  logic        clearn,
  output logic [15:0] digits,
  output logic        digit_strobe,
  output logic        entry_full
);
  logic w_press;
  logic [BCD_W-1:0] w_code;
  logic w_shift;
  logic [BCD_W*NUM_DIGITS-1:0] r_digits;
  logic [2:0] r_count;
  logic r_strobe;
  key_debouncer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
    .clk(clk),
    .resetn(resetn),
    .i_code(D),
    .i_loadn(loadn),
    .o_press_pulse(w_press),
    .o_code(w_code)
  );
  assign w_shift = w_press && !enablen && (w_code <= BCD_W'(MAX_DIGIT)) && (r_count < 3'(NUM_DIGITS));
  assign digits = r_digits;
  assign digit_strobe = r_strobe;
  assign entry_full = (r_count == 3'(NUM_DIGITS));
  // clear beats a same-edge shift; full or invalid presses leave the register untouched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_digits <= '0;
      r_count <= '0;
      r_strobe <= 1'b0;
    end else if (!clearn) begin
      r_digits <= '0;
      r_count <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_shift;
      if (w_shift) begin
        r_digits <= {r_digits[BCD_W*(NUM_DIGITS-1)-1:0], w_code};
        r_count <= r_count + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_digit_register.sv
// tb_keypad_digit_register: directed self-checking bench for keypad_digit_register
module tb_keypad_digit_register;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic loadn = 1'b1;
  logic enablen = 1'b0;
  logic clearn = 1'b1;
  logic [15:0] digits;
  logic digit_strobe;
  logic entry_full;
  int errors = 0;
  int checks = 0;
  int n_strobe = 0;
  logic prev_strobe = 1'b0;

  keypad_digit_register #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk(clk),
    .resetn(resetn),
    .D(D),
    .loadn(loadn),
    .enablen(enablen),
    .clearn(clearn),
    .digits(digits),
    .digit_strobe(digit_strobe),
    .entry_full(entry_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (digit_strobe) begin
      n_strobe++;
      checks++;
      if (prev_strobe) begin
        errors++;
        $display("FAIL strobe_consecutive: strobe=1 on two consecutive cycles, required single-cycle");
      end
    end
    prev_strobe = digit_strobe;
  end

  task automatic press(input logic [3:0] d, input int hold);
    @(negedge clk);
    D = d;
    loadn = 1'b0;
    repeat (hold) @(negedge clk);
    loadn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] dig, input logic full, input int strobes);
    checks++;
    if (digits !== dig) begin
      errors++;
      $display("FAIL %s_digits: got %h, required %h", name, digits, dig);
    end
    checks++;
    if (entry_full !== full) begin
      errors++;
      $display("FAIL %s_full: got %b, required %b", name, entry_full, full);
    end
    checks++;
    if (n_strobe !== strobes) begin
      errors++;
      $display("FAIL %s_strobes: got %0d, required %0d", name, n_strobe, strobes);
    end
  endtask

  task automatic test_latency(input string name, input logic [3:0] d, input logic [15:0] dig);
    int s0;
    s0 = n_strobe;
    @(negedge clk);
    D = d;
    loadn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (digit_strobe !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL %s_early: strobe=%b digits=%h, required 0/0000 after edge k+5", name, digit_strobe, digits);
    end
    @(posedge clk);
    #1;
    checks++;
    if (digit_strobe !== 1'b1 || digits !== dig) begin
      errors++;
      $display("FAIL %s_on_time: strobe=%b digits=%h, required 1/%h after edge k+6", name, digit_strobe, digits, dig);
    end
    @(posedge clk);
    #1;
    checks++;
    if (digit_strobe !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_width: strobe=%b, required 0 after edge k+7", name, digit_strobe);
    end
    repeat (13) @(negedge clk);
    loadn = 1'b1;
    repeat (10) @(negedge clk);
    expect_out(name, dig, 1'b0, s0 + 1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    expect_out("reset", 16'h0000, 1'b0, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    test_latency("first_press", 4'd5, 16'h0005);
  endtask

  task automatic test_fill();
    do_clear();
    press(4'd1, 10);
    press(4'd2, 10);
    press(4'd3, 10);
    expect_out("three", 16'h0123, 1'b0, 4);
    press(4'd0, 10);
    expect_out("full", 16'h1230, 1'b1, 5);
    press(4'd7, 10);
    expect_out("fifth", 16'h1230, 1'b1, 5);
  endtask

  task automatic test_bounce();
    do_clear();
    @(negedge clk);
    D = 4'd8;
    loadn = 1'b0;
    repeat (2) @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
    loadn = 1'b0;
    repeat (12) @(negedge clk);
    loadn = 1'b1;
    repeat (10) @(negedge clk);
    expect_out("bounce", 16'h0008, 1'b0, 6);
    press(4'd2, 100);
    expect_out("long_hold", 16'h0082, 1'b0, 7);
  endtask

  task automatic test_gating();
    enablen = 1'b1;
    press(4'd4, 10);
    expect_out("disabled", 16'h0082, 1'b0, 7);
    enablen = 1'b0;
    press(4'hA, 10);
    expect_out("invalid", 16'h0082, 1'b0, 7);
  endtask

  task automatic test_clear_collision();
    do_clear();
    press(4'd1, 10);
    press(4'd2, 10);
    expect_out("pre_clear", 16'h0012, 1'b0, 9);
    @(negedge clk);
    D = 4'd3;
    loadn = 1'b0;
    repeat (6) @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    repeat (4) @(negedge clk);
    loadn = 1'b1;
    repeat (10) @(negedge clk);
    expect_out("clear_collide", 16'h0000, 1'b0, 9);
    press(4'd9, 10);
    expect_out("after_clear", 16'h0009, 1'b0, 10);
    press(4'd1, 10);
    press(4'd2, 10);
    press(4'd3, 10);
    expect_out("refill", 16'h9123, 1'b1, 13);
  endtask

  task automatic test_mid_reset();
    do_clear();
    press(4'd7, 10);
    @(negedge clk);
    D = 4'd6;
    loadn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0000 || digit_strobe !== 1'b0 || entry_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: digits=%h strobe=%b full=%b, required 0000/0/0", digits, digit_strobe, entry_full);
    end
    loadn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    test_latency("post_reset", 4'd3, 16'h0003);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_bounce();
    test_gating();
    test_clear_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
